// File: rtl/mul_5bit_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_5bit_seq_if
// Description : Start/busy/done handshake bundle between decode and the
//               sequential multiplier (operands in, product and flags out).
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_5bit_seq_if #(
  parameter int WIDTH = 5
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               zf;
  logic               of;

  // Requester side: issues operands, observes status and result
  modport master (
    output start, a, b,
    input  busy, done, product, zf, of
  );

  // Multiplier side
  modport slave (
    input  start, a, b,
    output busy, done, product, zf, of
  );
endinterface
`default_nettype wire

// File: rtl/mul_5bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_5bit_seq
// Description : Sequential 5-bit unsigned shift-and-add multiplier. One pass
//               through the 5-bit ripple adder per cycle, five iterations,
//               registered 10-bit product with zero / overflow flags.
//               Also contains the adder_5bit ripple stage it drives.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// adder_5bit : 5-bit ripple-carry adder with carry/sign/zero status outputs
// ----------------------------------------------------------------------------
module adder_5bit (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       cin,
  output logic [4:0] s,
  output logic       cout,
  output logic       cf,
  output logic       sf,
  output logic       zf
);
  logic [5:0] w_carry;

  assign w_carry[0] = cin;

  // One full adder per bit, carry rippling upward
  generate
    for (genvar i = 0; i < 5; i++) begin : g_bit
      assign s[i]         = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = w_carry[5];
  assign cf   = w_carry[5];
  assign sf   = s[4];
  assign zf   = (s == 5'd0);
endmodule

// ----------------------------------------------------------------------------
// mul_5bit_seq : multi-cycle MUL unit
// ----------------------------------------------------------------------------
module mul_5bit_seq #(
  parameter int WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_5bit_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Final iteration happens when the counter reads this value
  localparam logic [2:0] LAST_ITER = 3'd4;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;

  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_q;
  logic               r_c;
  logic [2:0]         r_cnt;

  logic [2*WIDTH-1:0] r_product;
  logic               r_zf;
  logic               r_of;

  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [WIDTH:0]     w_ca;
  logic [WIDTH-1:0]   w_a_shift;
  logic [WIDTH-1:0]   w_q_shift;
  logic               w_last;

  // Partial-sum adder: A + M, no carry-in; status outputs are not needed here
  adder_5bit u_adder (
    .a    (r_a),
    .b    (r_m),
    .cin  (1'b0),
    .s    (w_sum),
    .cout (w_cout),
    .cf   (),
    .sf   (),
    .zf   ()
  );

  // Conditional add on Q[0], then logical right shift of {C,A,Q}.
  // The carry lands in A's MSB, so C is always zero between iterations.
  assign w_ca      = r_q[0] ? {w_cout, w_sum} : {r_c, r_a};
  assign w_a_shift = w_ca[WIDTH:1];
  assign w_q_shift = {w_ca[0], r_q[WIDTH-1:1]};
  assign w_last    = (r_cnt == LAST_ITER);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start only matters in IDLE, DONE lasts one cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state register only
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      S_RUN:   bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch operands on accept, iterate in RUN, publish result on last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_c       <= 1'b0;
      r_cnt     <= 3'd0;
      r_product <= '0;
      r_zf      <= 1'b1;
      r_of      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_m   <= bus.a;
            r_q   <= bus.b;
            r_a   <= '0;
            r_c   <= 1'b0;
            r_cnt <= 3'd0;
          end
        end
        S_RUN: begin
          r_a   <= w_a_shift;
          r_q   <= w_q_shift;
          r_c   <= 1'b0;
          r_cnt <= r_cnt + 3'd1;
          if (w_last) begin
            r_product <= {w_a_shift, w_q_shift};
            r_zf      <= ({w_a_shift, w_q_shift} == '0);
            r_of      <= |w_a_shift;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.product = r_product;
  assign bus.zf      = r_zf;
  assign bus.of      = r_of;
endmodule
`default_nettype wire

// File: tb/tb_mul_5bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_5bit_seq
// Description : Self-checking bench for mul_5bit_seq; expected results come
//               from plain integer multiplication of the issued operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_5bit_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mul_5bit_seq_if #(.WIDTH(5)) bus ();

  mul_5bit_seq #(.WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never terminates
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Issue one request from an idle DUT and wait for done (bounded).
  // Returns on the negedge of the done cycle; done_at counts negedges after accept.
  task automatic do_mul(input logic [4:0] ia, input logic [4:0] ib,
                        output int busy_cnt, output int done_at);
    bus.a = ia;
    bus.b = ib;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0;
    done_at  = 0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_at = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b expected busy=0 done=0", bus.busy, bus.done);
    end
    checks++;
    if (bus.product !== 10'd0 || bus.zf !== 1'b1 || bus.of !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: got product=%0d zf=%b of=%b expected product=0 zf=1 of=0",
               bus.product, bus.zf, bus.of);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 10'd0 ||
          bus.zf !== 1'b1 || bus.of !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: cycle %0d got busy=%b done=%b product=%0d zf=%b of=%b expected 0 0 0 1 0",
                 n, bus.busy, bus.done, bus.product, bus.zf, bus.of);
      end
    end
  endtask

  task automatic test_basic();
    int bc, da;
    do_mul(5'd21, 5'd12, bc, da);
    checks++;
    if (bc !== 5) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d expected 5", bc);
    end
    checks++;
    if (da !== 6) begin
      errors++;
      $display("FAIL basic_done_latency: got %0d expected 6", da);
    end
    checks++;
    if (bus.product !== 10'd252 || bus.zf !== 1'b0 || bus.of !== 1'b1) begin
      errors++;
      $display("FAIL basic_result: got product=%0d zf=%b of=%b expected product=252 zf=0 of=1",
               bus.product, bus.zf, bus.of);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b expected done=0 busy=0", bus.done, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int bc, da;
    do_mul(5'd31, 5'd31, bc, da);
    checks++;
    if (da !== 6 || bus.product !== 10'd961 || bus.of !== 1'b1 || bus.zf !== 1'b0) begin
      errors++;
      $display("FAIL max_result: got done_at=%0d product=%0d of=%b zf=%b expected 6 961 1 0",
               da, bus.product, bus.of, bus.zf);
    end
    // Hold start high from the done cycle on
    bus.a = 5'd1;
    bus.b = 5'd7;
    bus.start = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: got busy=%b done=%b expected busy=0 done=0", bus.busy, bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b expected busy=1", bus.busy);
    end
    bus.start = 1'b0;
    da = 0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.done === 1'b1) begin
        da = n;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (da !== 6 || bus.product !== 10'd7 || bus.of !== 1'b0 || bus.zf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: got done_at=%0d product=%0d of=%b zf=%b expected 6 7 0 0",
               da, bus.product, bus.of, bus.zf);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int bc, da;
    do_mul(5'b11100, 5'd0, bc, da);
    checks++;
    if (da !== 6 || bus.product !== 10'd0 || bus.zf !== 1'b1 || bus.of !== 1'b0) begin
      errors++;
      $display("FAIL zero_b: got done_at=%0d product=%0d zf=%b of=%b expected 6 0 1 0",
               da, bus.product, bus.zf, bus.of);
    end
    @(negedge clk);
    // Make the flags non-zero first so the second zero result is a real update
    do_mul(5'd3, 5'd5, bc, da);
    @(negedge clk);
    do_mul(5'd0, 5'd31, bc, da);
    checks++;
    if (da !== 6 || bus.product !== 10'd0 || bus.zf !== 1'b1 || bus.of !== 1'b0) begin
      errors++;
      $display("FAIL zero_a: got done_at=%0d product=%0d zf=%b of=%b expected 6 0 1 0",
               da, bus.product, bus.zf, bus.of);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int ndone, first, busy_after;
    logic [9:0] prod_at_done;
    bus.a = 5'd9;
    bus.b = 5'd13;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 5'd31;
    bus.b = 5'd31;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 5'd17;
    bus.b = 5'd2;
    ndone = 0;
    first = 0;
    busy_after = 0;
    prod_at_done = '0;
    for (int n = 3; n <= 18; n++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        if (first == 0) begin
          first = n;
          prod_at_done = bus.product;
        end
      end
      if (first != 0 && bus.busy === 1'b1) busy_after++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1 || first !== 6) begin
      errors++;
      $display("FAIL ignore_done_count: got count=%0d at=%0d expected count=1 at=6", ndone, first);
    end
    checks++;
    if (prod_at_done !== 10'(9 * 13)) begin
      errors++;
      $display("FAIL ignore_result: got %0d expected %0d", prod_at_done, 9 * 13);
    end
    checks++;
    if (busy_after !== 0) begin
      errors++;
      $display("FAIL ignore_no_requeue: got %0d busy cycles expected 0", busy_after);
    end
  endtask

  task automatic test_reset_mid();
    int bc, da, ndone;
    do_mul(5'd21, 5'd12, bc, da);
    checks++;
    if (bus.product !== 10'd252) begin
      errors++;
      $display("FAIL midrst_prior: got %0d expected 252", bus.product);
    end
    @(negedge clk);
    bus.a = 5'd31;
    bus.b = 5'd31;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.product !== 10'd0 || bus.zf !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_response: got product=%0d zf=%b busy=%b done=%b expected 0 1 0 0",
               bus.product, bus.zf, bus.busy, bus.done);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0 || bus.product !== 10'd0) begin
      errors++;
      $display("FAIL midrst_aborted: got activity=%0d product=%0d expected 0 0", ndone, bus.product);
    end
    do_mul(5'd3, 5'd3, bc, da);
    checks++;
    if (da !== 6 || bus.product !== 10'd9 || bus.zf !== 1'b0 || bus.of !== 1'b0) begin
      errors++;
      $display("FAIL midrst_recover: got done_at=%0d product=%0d zf=%b of=%b expected 6 9 0 0",
               da, bus.product, bus.zf, bus.of);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int bc, da, exp_p;
    logic [4:0] ra, rb;
    for (int i = 0; i < 24; i++) begin
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      exp_p = int'(ra) * int'(rb);
      do_mul(ra, rb, bc, da);
      checks++;
      if (bc !== 5 || da !== 6 || bus.product !== 10'(exp_p) ||
          bus.zf !== (exp_p == 0) || bus.of !== (exp_p >= 32)) begin
        errors++;
        $display("FAIL random %0d*%0d: got busy=%0d done_at=%0d product=%0d zf=%b of=%b expected 5 6 %0d %b %b",
                 ra, rb, bc, da, bus.product, bus.zf, bus.of, exp_p, (exp_p == 0), (exp_p >= 32));
      end
      // Random idle gap before the next request
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
